// File: rtl/pbkdf2_pkg.sv
// Shared types and constants for the PBKDF2-HMAC-SHA256 iteration controller.
package pbkdf2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int          MAX_SALT_BYTES = 51;
    localparam logic [31:0] BLK_IDX        = 32'h1;
    localparam int          PRF_W          = 256;
    localparam int          MSG_W          = 512;
    localparam logic [5:0]  U_LEN          = 6'd32;

    // Longest salt that still leaves room for INT(1) inside a single HMAC message.
    function automatic logic [5:0] sat_salt_len(input logic [5:0] len);
        logic [5:0] res;
        res = len;
        if (len > 6'(MAX_SALT_BYTES)) begin
            res = 6'(MAX_SALT_BYTES);
        end
        return res;
    endfunction

endpackage

// File: rtl/pbkdf2_msg_pack.sv
// Builds the HMAC message and byte length: salt || INT(1) on the first
// iteration, U_(j-1) left-aligned on every later iteration.
module pbkdf2_msg_pack
    import pbkdf2_pkg::*;
(
    input  logic             first,
    input  logic [MSG_W-1:0] salt,
    input  logic [5:0]       salt_len,
    input  logic [PRF_W-1:0] u,
    output logic [MSG_W-1:0] msg,
    output logic [5:0]       len
);

    logic [5:0]       len_sat;
    logic [8:0]       shift;
    logic [MSG_W-1:0] keep_mask;
    logic [MSG_W-1:0] blk_idx_word;

    always_comb begin
        msg          = '0;
        len          = '0;
        len_sat      = sat_salt_len(salt_len);
        shift        = {len_sat, 3'b000};
        // Ones over the first len_sat bytes; anything after that is upstream garbage.
        keep_mask    = ~({MSG_W{1'b1}} >> shift);
        blk_idx_word = {BLK_IDX, {(MSG_W-32){1'b0}}} >> shift;
        if (first) begin
            msg = (salt & keep_mask) | blk_idx_word;
            len = len_sat + 6'd4;
        end else begin
            msg = {u, {(MSG_W-PRF_W){1'b0}}};
            len = U_LEN;
        end
    end

endmodule

// File: rtl/pbkdf2_sha256_ctrl.sv
// PBKDF2-HMAC-SHA256 (dkLen 32, block 1) controller: requester on the HMAC
// interface, XOR-accumulates U1..Uc into DK. The hmac peer must be reset from rst_ni.
module pbkdf2_sha256_ctrl
    import pbkdf2_pkg::*;
#(
    parameter int ITER_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              v_i,
    output logic              r_o,
    input  logic [511:0]      pwd_i,
    input  logic [511:0]      salt_i,
    input  logic [5:0]        salt_len_i,
    input  logic [ITER_W-1:0] iter_i,
    output logic [255:0]      dk_o,
    output logic              v_o,
    input  logic              r_i,
    output logic [511:0]      hmac_key_o,
    output logic [511:0]      hmac_msg_o,
    output logic [5:0]        hmac_len_o,
    output logic              hmac_v_o,
    input  logic              hmac_r_i,
    input  logic [255:0]      hmac_prf_i,
    input  logic              hmac_v_i,
    output logic              hmac_r_o,
    output state_e            dbg_state_o
);

    // Handshakes: a transfer happens on the rising edge where valid and ready are
    // both high; valid, once raised, holds with its payload stable until that edge.

    state_e            state_q;
    state_e            state_d;
    logic [ITER_W-1:0] cnt_q;
    logic              first_q;
    logic [PRF_W-1:0]  t_q;
    logic [MSG_W-1:0]  key_q;
    logic [MSG_W-1:0]  msg_q;
    logic [5:0]        len_q;

    logic              accept;
    logic              rsp_hs;
    logic              last_iter;
    logic [MSG_W-1:0]  pack_msg;
    logic [5:0]        pack_len;

    assign accept    = (state_q == IDLE) && v_i;
    assign rsp_hs    = (state_q == WAIT) && hmac_v_i;
    assign last_iter = (cnt_q == ITER_W'(1));

    // In IDLE the packer forms the first message from the incoming job; in WAIT it
    // forms the next one from the arriving PRF, so msg_q is loaded at both events.
    pbkdf2_msg_pack u_msg_pack (
        .first    (state_q == IDLE),
        .salt     (salt_i),
        .salt_len (salt_len_i),
        .u        (hmac_prf_i),
        .msg      (pack_msg),
        .len      (pack_len)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (v_i)      state_d = REQ;
            REQ:     if (hmac_r_i) state_d = WAIT;
            WAIT:    if (hmac_v_i) state_d = last_iter ? DONE : REQ;
            DONE:    if (r_i)      state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            first_q <= 1'b0;
            t_q     <= '0;
            key_q   <= '0;
            msg_q   <= '0;
            len_q   <= '0;
        end else begin
            if (accept) begin
                key_q   <= pwd_i;
                msg_q   <= pack_msg;
                len_q   <= pack_len;
                cnt_q   <= (iter_i == '0) ? ITER_W'(1) : iter_i;
                first_q <= 1'b1;
            end
            // Counting down to 1 lets the all-ones count finish without wrapping.
            if (rsp_hs) begin
                t_q     <= first_q ? hmac_prf_i : (t_q ^ hmac_prf_i);
                first_q <= 1'b0;
                cnt_q   <= cnt_q - ITER_W'(1);
                msg_q   <= pack_msg;
                len_q   <= pack_len;
            end
        end
    end

    assign r_o         = (state_q == IDLE);
    assign hmac_v_o    = (state_q == REQ);
    assign hmac_r_o    = (state_q == WAIT);
    assign v_o         = (state_q == DONE);
    assign dk_o        = t_q;
    assign hmac_key_o  = key_q;
    assign hmac_msg_o  = msg_q;
    assign hmac_len_o  = len_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pbkdf2_sha256_ctrl.sv
// Bench for pbkdf2_sha256_ctrl: a behavioural HMAC-SHA256 peer plus table-driven jobs.
module tb_pbkdf2_sha256_ctrl;
    import pbkdf2_pkg::*;

    localparam int ITER_W = 32;

    localparam logic [255:0] DK1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [255:0] DK2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
    localparam logic [255:0] DK4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;

    localparam logic [255:0] SHA_IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic              clk;
    logic              rst_n;
    logic              v_i;
    logic              r_o;
    logic [511:0]      pwd_i;
    logic [511:0]      salt_i;
    logic [5:0]        salt_len_i;
    logic [ITER_W-1:0] iter_i;
    logic [255:0]      dk_o;
    logic              v_o;
    logic              r_i;
    logic [511:0]      hmac_key_o;
    logic [511:0]      hmac_msg_o;
    logic [5:0]        hmac_len_o;
    logic              hmac_v_o;
    logic              hmac_r_i;
    logic [255:0]      hmac_prf_i;
    logic              hmac_v_i;
    logic              hmac_r_o;
    state_e            dbg_state;

    pbkdf2_sha256_ctrl #(.ITER_W(ITER_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .v_i         (v_i),
        .r_o         (r_o),
        .pwd_i       (pwd_i),
        .salt_i      (salt_i),
        .salt_len_i  (salt_len_i),
        .iter_i      (iter_i),
        .dk_o        (dk_o),
        .v_o         (v_o),
        .r_i         (r_i),
        .hmac_key_o  (hmac_key_o),
        .hmac_msg_o  (hmac_msg_o),
        .hmac_len_o  (hmac_len_o),
        .hmac_v_o    (hmac_v_o),
        .hmac_r_i    (hmac_r_i),
        .hmac_prf_i  (hmac_prf_i),
        .hmac_v_i    (hmac_v_i),
        .hmac_r_o    (hmac_r_o),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           errors = 0;
    logic [255:0] exp_q[$];

    task automatic check_w(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference SHA-256 / HMAC ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + SHA_K[t] + w[t];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // HMAC-SHA256 with a 64-byte key and a message of at most 55 bytes.
    function automatic logic [255:0] hmac_model(input logic [511:0] key, input logic [511:0] msg, input logic [5:0] len);
        logic [511:0] ones;
        logic [511:0] pad0;
        logic [511:0] blk;
        logic [255:0] hs;
        logic [255:0] inner;
        ones = '1;
        pad0 = {8'h80, 504'h0};
        hs   = sha_compress(SHA_IV, key ^ {64{8'h36}});
        blk  = (msg & ~(ones >> (8 * int'(len)))) | (pad0 >> (8 * int'(len)));
        blk[63:0] = 64'((64 + int'(len)) * 8);
        inner = sha_compress(hs, blk);
        hs    = sha_compress(SHA_IV, key ^ {64{8'h5c}});
        return sha_compress(hs, {inner, 8'h80, 184'h0, 64'd768});
    endfunction

    // ---------------- HMAC peer ----------------
    bit           gaps;
    int           exp_iters;
    int           n_req;
    int           n_rsp;
    int           delay;
    bit           busy;
    bit           req_fire;
    bit           rsp_fire;
    bit           held_valid;
    logic [511:0] cap_key;
    logic [511:0] cap_msg;
    logic [5:0]   cap_len;
    logic [255:0] rsp_val;

    initial begin
        hmac_r_i = 1'b0; hmac_v_i = 1'b0; hmac_prf_i = '0;
        busy = 0; req_fire = 0; rsp_fire = 0; held_valid = 0; delay = 0;
        n_req = 0; n_rsp = 0; exp_iters = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0; req_fire = 0; rsp_fire = 0; held_valid = 0;
                hmac_r_i = 1'b0; hmac_v_i = 1'b0;
            end else begin
                if (rsp_fire) begin
                    rsp_fire = 0; busy = 0; hmac_v_i = 1'b0; n_rsp++;
                    if (n_rsp < exp_iters) check_bit("next_req_after_rsp", hmac_v_o, 1'b1);
                    else check_bit("v_o_after_last_rsp", v_o, 1'b1);
                end
                if (req_fire) begin
                    req_fire = 0; busy = 1; n_req++;
                    rsp_val  = hmac_model(cap_key, cap_msg, cap_len);
                    delay    = gaps ? $urandom_range(1, 4) : $urandom_range(1, 2);
                end
                if (hmac_v_o) begin
                    check_bit("req_while_outstanding", busy, 1'b0);
                    if (held_valid) begin
                        check_w("hmac_key_stable", hmac_key_o, cap_key);
                        check_w("hmac_msg_stable", hmac_msg_o, cap_msg);
                        check_int("hmac_len_stable", int'(hmac_len_o), int'(cap_len));
                    end else begin
                        cap_key = hmac_key_o; cap_msg = hmac_msg_o; cap_len = hmac_len_o;
                        held_valid = 1;
                    end
                    hmac_r_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                    if (hmac_r_i) begin
                        req_fire   = 1;
                        held_valid = 0;
                    end
                end else begin
                    hmac_r_i = 1'b0;
                end
                if (busy) begin
                    check_bit("hmac_r_o_in_wait", hmac_r_o, 1'b1);
                    if (!hmac_v_i) begin
                        if (delay > 0) delay--;
                        else begin
                            hmac_v_i   = 1'b1;
                            hmac_prf_i = rsp_val;
                        end
                    end
                    rsp_fire = hmac_v_i && hmac_r_o;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_vals(input string tag);
        check_bit({tag, "_r_o"}, r_o, 1'b1);
        check_bit({tag, "_v_o"}, v_o, 1'b0);
        check_bit({tag, "_hmac_v_o"}, hmac_v_o, 1'b0);
        check_bit({tag, "_hmac_r_o"}, hmac_r_o, 1'b0);
        check_w({tag, "_dk_o"}, 512'(dk_o), '0);
        check_w({tag, "_hmac_key_o"}, hmac_key_o, '0);
        check_w({tag, "_hmac_msg_o"}, hmac_msg_o, '0);
        check_int({tag, "_hmac_len_o"}, int'(hmac_len_o), 0);
        check_int({tag, "_state"}, int'(dbg_state), int'(IDLE));
    endtask

    task automatic start_job(input logic [511:0] pwd, input logic [511:0] salt, input logic [5:0] slen,
                             input logic [ITER_W-1:0] iter, input logic [255:0] exp_dk, input bit do_gaps);
        @(negedge clk);
        check_bit("r_o_idle", r_o, 1'b1);
        gaps      = do_gaps;
        n_req     = 0;
        n_rsp     = 0;
        exp_iters = (iter == 0) ? 1 : int'(iter);
        pwd_i = pwd; salt_i = salt; salt_len_i = slen; iter_i = iter;
        v_i   = 1'b1;
        exp_q.push_back(exp_dk);
        @(negedge clk);
        v_i = 1'b0;
        check_bit("hmac_v_o_after_accept", hmac_v_o, 1'b1);
        check_bit("r_o_busy", r_o, 1'b0);
    endtask

    task automatic finish_job(input int budget, input bit do_gaps, input bit v_at_retire);
        int           cyc;
        logic [255:0] held;
        logic [255:0] exp;
        cyc = 0;
        while (!v_o && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        exp = exp_q.pop_front();
        check_bit("dk_valid_within_budget", v_o, 1'b1);
        if (!v_o) return;
        check_w("dk_o", 512'(dk_o), 512'(exp));
        held = dk_o;
        if (do_gaps) begin
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                check_bit("v_o_held", v_o, 1'b1);
                check_w("dk_o_stable", 512'(dk_o), 512'(held));
            end
        end
        r_i = 1'b1;
        v_i = v_at_retire;
        @(negedge clk);
        r_i = 1'b0;
        v_i = 1'b0;
        check_bit("v_o_retired", v_o, 1'b0);
        check_bit("r_o_after_retire", r_o, 1'b1);
        check_bit("no_accept_on_retire", hmac_v_o, 1'b0);
        check_int("hmac_handshakes", n_req, exp_iters);
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        string             name;
        logic [511:0]      salt;
        logic [5:0]        salt_len;
        logic [ITER_W-1:0] iter;
        logic [255:0]      exp_dk;
        bit                gaps;
    } vec_t;

    vec_t         vecs[6];
    logic [511:0] pwd;
    logic [511:0] salt_clean;
    logic [511:0] salt_rand;
    logic [511:0] exp_msg;
    logic [255:0] exp_dk60;
    int           cyc;

    initial begin
        rst_n = 1'b1; v_i = 1'b0; r_i = 1'b0;
        pwd_i = '0; salt_i = '0; salt_len_i = '0; iter_i = '0;
        #1 rst_n = 1'b0;
        #1 check_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        pwd        = {"password", 448'h0};
        salt_clean = {"salt", 480'h0};
        for (int i = 0; i < 16; i++) salt_rand[32*i +: 32] = $urandom;

        vecs[0] = '{"c1",          salt_clean,                           6'd4, 32'd1,    DK1,    1'b0};
        vecs[1] = '{"c2",          salt_clean,                           6'd4, 32'd2,    DK2,    1'b0};
        vecs[2] = '{"c0_as_c1",    salt_clean,                           6'd4, 32'd0,    DK1,    1'b0};
        vecs[3] = '{"c2_gaps",     salt_clean,                           6'd4, 32'd2,    DK2,    1'b1};
        vecs[4] = '{"salt_garbage", {"salt", salt_rand[479:0]},          6'd4, 32'd1,    DK1,    1'b1};
        vecs[5] = '{"c4096",       salt_clean,                           6'd4, 32'd4096, DK4096, 1'b0};

        for (int v = 0; v < 6; v++) begin
            start_job(pwd, vecs[v].salt, vecs[v].salt_len, vecs[v].iter, vecs[v].exp_dk, vecs[v].gaps);
            finish_job(exp_iters * 20 + 50, vecs[v].gaps, 1'b0);
        end

        // Over-long salt saturates to 51 bytes with INT(1) in bytes 51..54.
        exp_msg = '0;
        for (int i = 0; i < 51; i++) exp_msg[511-8*i -: 8] = salt_rand[511-8*i -: 8];
        exp_msg[511-8*54 -: 8] = 8'h01;
        exp_dk60 = hmac_model(pwd, exp_msg, 6'd55);
        start_job(pwd, salt_rand, 6'd60, 32'd1, exp_dk60, 1'b0);
        check_int("salt60_hmac_len", int'(hmac_len_o), 55);
        check_w("salt60_hmac_msg", hmac_msg_o, exp_msg);
        check_w("salt60_hmac_key", hmac_key_o, pwd);
        finish_job(100, 1'b0, 1'b0);

        // v_i pulsed while busy with different job data, and again at retire.
        start_job(pwd, salt_clean, 6'd4, 32'd2, DK2, 1'b0);
        repeat (3) begin
            @(negedge clk);
            v_i = 1'b1; iter_i = 32'd7; salt_i = salt_rand; pwd_i = ~pwd;
            check_bit("r_o_busy_pulse", r_o, 1'b0);
        end
        @(negedge clk);
        v_i = 1'b0;
        check_bit("r_o_after_pulse", r_o, 1'b0);
        finish_job(100, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_bit("no_second_job_hmac_v_o", hmac_v_o, 1'b0);
        check_bit("no_second_job_r_o", r_o, 1'b1);

        // Asynchronous reset during WAIT of the third iteration.
        start_job(pwd, salt_clean, 6'd4, 32'd5, DK1, 1'b0);
        cyc = 0;
        while (!(n_req == 3 && hmac_r_o) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_bit("reached_iter3_wait", hmac_r_o, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("midjob_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_job(pwd, salt_clean, 6'd4, 32'd1, DK1, 1'b0);
        finish_job(100, 1'b0, 1'b0);

        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pbkdf2_sha256_ctrl.md
# pbkdf2_sha256_ctrl

Single-block PBKDF2-HMAC-SHA256 iteration controller: the requester on the HMAC request/response interface. Accepts a password, salt and iteration count from upstream, then drives `hmac_sha256` through U1 = PRF(P, S‖INT(1)) and Uj = PRF(P, Uj-1). It XOR-accumulates T = U1 ⊕ … ⊕ Uc and returns the 256-bit derived key DK (dkLen = 32, block index fixed to 1).

## Interface
- `ITER_W`, default 32: width of the iteration count.
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `v_i`  in  1  upstream job valid.
- `r_o`  out  1  ready for a job; high only in IDLE.
- `pwd_i`  in  512  password, left-aligned, zero-filled right; used as the HMAC key.
- `salt_i`  in  512  salt, left-aligned; bytes at or beyond `salt_len_i` are ignored.
- `salt_len_i`  in  6  salt length in bytes; valid range 0–51.
- `iter_i`  in  ITER_W  iteration count c.
- `dk_o`  out  256  derived key T.
- `v_o`  out  1  `dk_o` valid.
- `r_i`  in  1  downstream ready.
- `hmac_key_o`  out  512  to hmac `key_i`.
- `hmac_msg_o`  out  512  to hmac `msg_i`.
- `hmac_len_o`  out  6  to hmac `msg_len_i`; message length in bytes.
- `hmac_v_o`  out  1  to hmac `v_i`.
- `hmac_r_i`  in  1  from hmac `r_o`.
- `hmac_prf_i`  in  256  from hmac `prf_o`.
- `hmac_v_i`  in  1  from hmac `v_o`.
- `hmac_r_o`  out  1  to hmac `r_i`.

## Operation
- **IDLE:** `r_o` = 1.
  - On `v_i && r_o`, latch the inputs.
  - `salt_len_i` > 51 saturates to 51.
  - `iter_i` = 0 is treated as 1.
  - Load the remaining-iteration counter with c; set `first` = 1. Go to REQ.
- **REQ:** `hmac_v_o` = 1; the key, message and length are driven from registers and held stable until the handshake.
  - First iteration:
    - message = masked salt OR ({32'h0000_0001, 480'b0} >> 8·salt_len), with salt bytes at or beyond salt_len forced to 0.
    - length = salt_len + 4 (maximum 55).
  - Later iterations: message = {U, 256'b0}; length = 32.
  - On `hmac_v_o && hmac_r_i`, drop `hmac_v_o` in the same edge and go to WAIT.
- **WAIT:** `hmac_r_o` = 1. On `hmac_v_i && hmac_r_o`:
  - U ← `hmac_prf_i`.
  - T ← `first` ? `hmac_prf_i` : T ⊕ `hmac_prf_i`.
  - `first` ← 0; counter −1.
  - If the counter was 1, go to DONE; otherwise go to REQ.
- **DONE:** `v_o` = 1 and `dk_o` = T, stable. On `r_i`, go to IDLE.
- `hmac_r_o` is low outside WAIT, and `hmac_v_o` is low outside REQ. No request is ever issued while a response is outstanding.
- Counter arithmetic is unsigned ITER_W-bit. The maximum count 2^ITER_W − 1 must complete without wrap.

## Timing
- Reset values of outputs:
  - `r_o` = 1.
  - `v_o`, `hmac_v_o` and `hmac_r_o` = 0.
  - `dk_o`, `hmac_key_o`, `hmac_msg_o` and `hmac_len_o` = 0.
  - The FSM is in IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Job accept at edge n puts `hmac_v_o` = 1 from cycle n+1.
- After the response handshake, the next `hmac_v_o` rises the following cycle, or `v_o` rises the following cycle on the last iteration.
- Total latency = c·(L_hmac + 2) + 1 cycles, where L_hmac is the HMAC request-to-response time.
- `v_i` asserted while busy is ignored: `r_o` = 0 and nothing is latched.
- Simultaneous `v_o && r_i`: the job retires and `r_o` rises the next cycle. A new job cannot be accepted in the same cycle it retires.
- Reset asserted mid-job clears all state immediately. The hmac peer must share the same reset event; top level supplies the hmac active-high synchronous reset from `rst_ni`.

## Structure
- `pbkdf2_pkg`:
  - state enum {IDLE, REQ, WAIT, DONE}.
  - `MAX_SALT_BYTES` = 51, `BLK_IDX` = 32'h1, `PRF_W` = 256, `MSG_W` = 512, `U_LEN` = 6'd32.
- Sub-module `pbkdf2_msg_pack`: combinational salt masking and INT(1) insertion; outputs the message and the length.

## Test plan
- pwd "password", salt "salt" (len 4), c = 1 → `dk_o` = 120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b; exactly one hmac handshake.
- Same inputs, c = 2 → ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43; c = 4096 → c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a.
- c = 0 → identical result to c = 1. `salt_len_i` = 60 → `hmac_len_o` = 55 on the first request, with INT(1) at bytes 51–54.
- Random gaps on `hmac_r_i`, `hmac_v_i` and `r_i` → `hmac_*_o` and `dk_o` remain stable while stalled; the DK is unchanged.
- Garbage in salt bytes beyond salt_len, and `v_i` pulsed while busy → DK matches the clean-salt value; the second job is not accepted.
- `rst_ni` low during WAIT of iteration 3 → all outputs go to reset values asynchronously; a following job (c = 1) returns the correct DK.
